knight_motion_ctrl: RTL and testbench
=====================================

Name: knight_motion_ctrl

Overview:
- Sequences the Knight's movement datapath once per frame.
- Decodes up to four simultaneous USB keycodes and arbitrates conflicting keys.
- Runs a walk/jump/fall state machine and drives registered per-frame x/y step commands plus an animation status code to the position/collision datapath.
- Replaces ad-hoc keycode-to-motion mapping, giving edge-triggered variable-height jumps, an apex hang, air control and fast-fall.

Parameters:
- WALK_SPEED, 2, horizontal step magnitude per frame (ground and air)
- JUMP_SPEED, 6, upward step magnitude per frame in RISE
- FALL_SPEED, 6, downward step magnitude per frame in FALL
- FAST_FALL, 9, downward step magnitude in FALL while down key held
- RISE_FRAMES, 18, maximum frames spent in RISE
- MIN_RISE, 4, minimum RISE frames before key release can end the rise
- APEX_FRAMES, 3, frames of zero vertical motion at apex

Ports:
- frame_clk  in  1  frame-rate clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high
- keycode0..keycode3  in  8 each  USB HID report key slots; 8'h00 = empty
- on_ground  in  1  datapath: Knight bottom rests on floor/platform this frame
- hit_ceiling  in  1  datapath: Knight top clamped at upper bound this frame
- x_step  out  10  signed two's-complement horizontal step
- y_step  out  10  signed two's-complement vertical step; negative = up
- status  out  4  0 idle, 1 walk, 2 jump-up, 3 falling (apex reports 2)
- facing  out  1  1 = right, 0 = left

Behaviour:
- Reset state: IDLE, x_step=0, y_step=0, status=0, facing=1, frame counter=0, up_prev=0.
- Key decode: a key is pressed if any slot equals its code. Codes: left 8'h50, right 8'h4F, down 8'h51, up 8'h52. Slot order is irrelevant.
- Horizontal arbitration:
  - left only gives x_step=-WALK_SPEED and facing=0.
  - right only gives x_step=+WALK_SPEED and facing=1.
  - Both or neither gives x_step=0 and leaves facing unchanged.
  - Applies in every state. Steps are sign-extended to 10 bits.
- Jump trigger: up_edge = up & ~up_prev. up_prev is registered every frame. Holding up never re-triggers a jump.
- All outputs are registered. Inputs sampled at edge k are reflected in outputs after edge k (latency 1 frame).
- Counter: 8-bit, cleared on every state entry, saturates at 255.
- IDLE / WALK (y_step=0):
  - If ~on_ground, go to FALL. This takes priority over up_edge (walking off a ledge cannot jump).
  - Else if up_edge, go to RISE with y_step=-JUMP_SPEED and cnt=1.
  - Else the state is WALK when horizontal is nonzero, otherwise IDLE. Status is 1 or 0 accordingly.
  - Down on ground has no effect.
- RISE (status 2, y_step=-JUMP_SPEED). on_ground is ignored.
  - If hit_ceiling, go to FALL. This has top priority.
  - Else if cnt==RISE_FRAMES, go to APEX.
  - Else if ~up and cnt>=MIN_RISE, go to APEX.
  - Otherwise cnt++.
- APEX (status 2, y_step=0):
  - If on_ground, go to IDLE/WALK.
  - Else after APEX_FRAMES frames in APEX, go to FALL.
- FALL (status 3):
  - y_step=+FAST_FALL if down is held, else +FALL_SPEED. Re-evaluated each frame.
  - If on_ground, land: same edge goes to IDLE/WALK with y_step=0. up_edge on the landing frame is ignored.
- Invalid state encoding recovers to FALL.
- Reset asserted mid-jump returns everything to reset values immediately (asynchronous).

Decomposition:
- Shared package knight_pkg holds:
  - state enum {IDLE, WALK, RISE, APEX, FALL}
  - keycode constants KEY_LEFT, KEY_RIGHT, KEY_DOWN, KEY_UP
  - status constants ST_IDLE, ST_WALK, ST_JUMP, ST_FALL
- One natural sub-module: knight_key_decode. It is combinational and turns the 4 slots into left/right/up/down bits. It is reused later by the attack controller.

Test Plan:
- Reset mid-RISE (cnt=7), release -> x_step=0, y_step=0, status=0, facing=1 immediately; next up_edge with on_ground=1 starts RISE.
- keycode0=8'h4F, on_ground=1 -> after 1 edge x_step=+2, status=1, facing=1; add keycode2=8'h50 -> x_step=0, status=0, facing stays 1.
- up held from frame 0, on_ground=1 -> 18 frames y_step=-6, 3 frames y_step=0 (status 2), then y_step=+6 (status 3). Raise on_ground -> y_step=0, status 0; up still held, no new jump.
- up tapped for 1 frame -> RISE lasts exactly MIN_RISE=4 frames, then APEX; hit_ceiling at RISE frame 2 -> next frame y_step=+6, status 3.
- on_ground drops while WALK and up_edge same frame -> FALL (y_step=+6), no RISE; hold down (8'h51 in slot 3) -> y_step=+9; release -> +6.
- keycode1=8'h50 during FALL -> x_step=-2, facing=0, y_step unchanged.

Source files
------------

// File: rtl/knight_pkg.sv
// Shared types and constants for the Knight controllers.
package knight_pkg;

    localparam int unsigned KEY_W    = 8;
    localparam int unsigned STEP_W   = 10;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned STATUS_W = 4;

    localparam logic [KEY_W-1:0] KEY_RIGHT = 8'h4F;
    localparam logic [KEY_W-1:0] KEY_LEFT  = 8'h50;
    localparam logic [KEY_W-1:0] KEY_DOWN  = 8'h51;
    localparam logic [KEY_W-1:0] KEY_UP    = 8'h52;

    localparam logic [STATUS_W-1:0] ST_IDLE = 4'd0;
    localparam logic [STATUS_W-1:0] ST_WALK = 4'd1;
    localparam logic [STATUS_W-1:0] ST_JUMP = 4'd2;
    localparam logic [STATUS_W-1:0] ST_FALL = 4'd3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WALK = 3'd1,
        RISE = 3'd2,
        APEX = 3'd3,
        FALL = 3'd4
    } state_e;

    typedef struct packed {
        logic left;
        logic right;
        logic up;
        logic down;
    } keys_t;

endpackage

// File: rtl/knight_key_decode.sv
// Turns four USB HID key slots into direction bits; slot order is irrelevant.
module knight_key_decode
    import knight_pkg::*;
(
    input  logic [KEY_W-1:0] keycode0_i,
    input  logic [KEY_W-1:0] keycode1_i,
    input  logic [KEY_W-1:0] keycode2_i,
    input  logic [KEY_W-1:0] keycode3_i,
    output keys_t            keys_c
);

    // A key counts as pressed when any slot carries its code.
    always_comb begin
        keys_c       = '0;
        keys_c.left  = (keycode0_i == KEY_LEFT)  || (keycode1_i == KEY_LEFT)  ||
                       (keycode2_i == KEY_LEFT)  || (keycode3_i == KEY_LEFT);
        keys_c.right = (keycode0_i == KEY_RIGHT) || (keycode1_i == KEY_RIGHT) ||
                       (keycode2_i == KEY_RIGHT) || (keycode3_i == KEY_RIGHT);
        keys_c.up    = (keycode0_i == KEY_UP)    || (keycode1_i == KEY_UP)    ||
                       (keycode2_i == KEY_UP)    || (keycode3_i == KEY_UP);
        keys_c.down  = (keycode0_i == KEY_DOWN)  || (keycode1_i == KEY_DOWN)  ||
                       (keycode2_i == KEY_DOWN)  || (keycode3_i == KEY_DOWN);
    end

endmodule

// File: rtl/knight_motion_ctrl.sv
// Per-frame walk/jump/fall sequencer producing registered step commands.
module knight_motion_ctrl
    import knight_pkg::*;
#(
    parameter int unsigned WALK_SPEED  = 2,
    parameter int unsigned JUMP_SPEED  = 6,
    parameter int unsigned FALL_SPEED  = 6,
    parameter int unsigned FAST_FALL   = 9,
    parameter int unsigned RISE_FRAMES = 18,
    parameter int unsigned MIN_RISE    = 4,
    parameter int unsigned APEX_FRAMES = 3
) (
    input  logic                frame_clk,
    input  logic                Reset,
    input  logic [KEY_W-1:0]    keycode0,
    input  logic [KEY_W-1:0]    keycode1,
    input  logic [KEY_W-1:0]    keycode2,
    input  logic [KEY_W-1:0]    keycode3,
    input  logic                on_ground,
    input  logic                hit_ceiling,
    output logic [STEP_W-1:0]   x_step,
    output logic [STEP_W-1:0]   y_step,
    output logic [STATUS_W-1:0] status,
    output logic                facing
);

    localparam logic [STEP_W-1:0] WALK_POS = STEP_W'(WALK_SPEED);
    localparam logic [STEP_W-1:0] WALK_NEG = -WALK_POS;
    localparam logic [STEP_W-1:0] JUMP_POS = STEP_W'(JUMP_SPEED);
    localparam logic [STEP_W-1:0] JUMP_NEG = -JUMP_POS;
    localparam logic [STEP_W-1:0] FALL_Y   = STEP_W'(FALL_SPEED);
    localparam logic [STEP_W-1:0] FAST_Y   = STEP_W'(FAST_FALL);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    keys_t                keys;
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 up_prev_q;
    logic [STEP_W-1:0]    x_step_q, x_step_d;
    logic [STEP_W-1:0]    y_step_q, y_step_d;
    logic [STATUS_W-1:0]  status_q, status_d;
    logic                 facing_q, facing_d;
    logic                 up_edge;
    logic                 horiz_move;
    state_e               ground_state;
    logic [STEP_W-1:0]    fall_y;

    knight_key_decode u_key_decode (
        .keycode0_i (keycode0),
        .keycode1_i (keycode1),
        .keycode2_i (keycode2),
        .keycode3_i (keycode3),
        .keys_c     (keys)
    );

    assign up_edge      = keys.up & ~up_prev_q;
    assign horiz_move   = keys.left ^ keys.right;
    assign ground_state = horiz_move ? WALK : IDLE;
    assign fall_y       = keys.down ? FAST_Y : FALL_Y;

    // State, counter, key history and output registers.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            up_prev_q <= 1'b0;
            x_step_q  <= '0;
            y_step_q  <= '0;
            status_q  <= ST_IDLE;
            facing_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            up_prev_q <= keys.up;
            x_step_q  <= x_step_d;
            y_step_q  <= y_step_d;
            status_q  <= status_d;
            facing_q  <= facing_d;
        end
    end

    // Next-state, counter and step selection for the coming frame.
    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        x_step_d = '0;
        y_step_d = '0;
        status_d = ST_IDLE;
        facing_d = facing_q;

        // Horizontal arbitration is independent of the vertical state.
        if (keys.left && !keys.right) begin
            x_step_d = WALK_NEG;
            facing_d = 1'b0;
        end else if (keys.right && !keys.left) begin
            x_step_d = WALK_POS;
            facing_d = 1'b1;
        end

        case (state_q)
            IDLE, WALK: begin
                if (!on_ground) begin
                    state_d  = FALL;
                    y_step_d = fall_y;
                end else if (up_edge) begin
                    state_d  = RISE;
                    y_step_d = JUMP_NEG;
                end else begin
                    state_d  = ground_state;
                end
            end
            RISE: begin
                y_step_d = JUMP_NEG;
                if (hit_ceiling) begin
                    state_d  = FALL;
                    y_step_d = fall_y;
                end else if (cnt_q == CNT_W'(RISE_FRAMES)) begin
                    state_d  = APEX;
                    y_step_d = '0;
                end else if (!keys.up && (cnt_q >= CNT_W'(MIN_RISE))) begin
                    state_d  = APEX;
                    y_step_d = '0;
                end
            end
            APEX: begin
                if (on_ground) begin
                    state_d = ground_state;
                end else if (cnt_q >= CNT_W'(APEX_FRAMES - 1)) begin
                    state_d  = FALL;
                    y_step_d = fall_y;
                end
            end
            FALL: begin
                y_step_d = fall_y;
                if (on_ground) begin
                    state_d  = ground_state;
                    y_step_d = '0;
                end
            end
            default: begin
                state_d  = FALL;
                y_step_d = fall_y;
            end
        endcase

        // Fresh count on every state change; a jump starts on its first frame.
        if (state_d != state_q) begin
            cnt_d = (state_d == RISE) ? CNT_W'(1) : '0;
        end

        case (state_d)
            WALK:       status_d = ST_WALK;
            RISE, APEX: status_d = ST_JUMP;
            FALL:       status_d = ST_FALL;
            default:    status_d = ST_IDLE;
        endcase
    end

    assign x_step = x_step_q;
    assign y_step = y_step_q;
    assign status = status_q;
    assign facing = facing_q;

endmodule

// File: tb/tb_knight_motion_ctrl.sv
// Directed bench for knight_motion_ctrl with hand-computed expectations.
module tb_knight_motion_ctrl;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode0, keycode1, keycode2, keycode3;
    logic       on_ground, hit_ceiling;
    logic [9:0] x_step, y_step;
    logic [3:0] status;
    logic       facing;

    int n_checks = 0;
    int n_errors = 0;

    knight_motion_ctrl dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .keycode0    (keycode0),
        .keycode1    (keycode1),
        .keycode2    (keycode2),
        .keycode3    (keycode3),
        .on_ground   (on_ground),
        .hit_ceiling (hit_ceiling),
        .x_step      (x_step),
        .y_step      (y_step),
        .status      (status),
        .facing      (facing)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input int ex, input int ey,
                             input int est, input int ef);
        check({tag, ".x"}, int'($signed(x_step)), ex);
        check({tag, ".y"}, int'($signed(y_step)), ey);
        check({tag, ".status"}, int'(status), est);
        check({tag, ".facing"}, int'(facing), ef);
    endtask

    // Advance one frame and sample just after the edge.
    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        keycode0 = 8'h00; keycode1 = 8'h00; keycode2 = 8'h00; keycode3 = 8'h00;
        on_ground = 1'b1; hit_ceiling = 1'b0;
        #1;
        check_out("reset", 0, 0, 0, 1);
        #12;
        Reset = 1'b0;
        step();
        check_out("idle", 0, 0, 0, 1);

        // Walking right, then conflicting left cancels motion.
        keycode0 = 8'h4F;
        step();
        check_out("walk_r", 2, 0, 1, 1);
        keycode2 = 8'h50;
        step();
        check_out("both_lr", 0, 0, 0, 1);
        keycode0 = 8'h00; keycode2 = 8'h00;
        step();

        // Full-height jump with up held throughout.
        keycode1 = 8'h52;
        step();
        check_out("rise1", 0, -6, 2, 1);
        on_ground = 1'b0;
        for (int i = 2; i <= 18; i++) begin
            step();
            check($sformatf("rise%0d.y", i), int'($signed(y_step)), -6);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("apex%0d.y", i), int'($signed(y_step)), 0);
            check($sformatf("apex%0d.status", i), int'(status), 2);
        end
        step();
        check_out("fall1", 0, 6, 3, 1);
        on_ground = 1'b1;
        step();
        check_out("land", 0, 0, 0, 1);
        step();
        check_out("held_no_rejump", 0, 0, 0, 1);

        // Tap up for one frame: rise lasts MIN_RISE frames.
        keycode1 = 8'h00;
        step();
        keycode1 = 8'h52;
        step();
        check_out("tap_rise1", 0, -6, 2, 1);
        keycode1 = 8'h00;
        on_ground = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            step();
            check($sformatf("tap_rise%0d.y", i), int'($signed(y_step)), -6);
        end
        step();
        check_out("tap_apex", 0, 0, 2, 1);
        on_ground = 1'b1;
        step();
        check_out("apex_land", 0, 0, 0, 1);

        // Ceiling hit during the second rise frame.
        keycode1 = 8'h52;
        step();
        check_out("ceil_rise1", 0, -6, 2, 1);
        on_ground = 1'b0;
        step();
        check_out("ceil_rise2", 0, -6, 2, 1);
        hit_ceiling = 1'b1;
        step();
        check_out("ceil_fall", 0, 6, 3, 1);
        hit_ceiling = 1'b0;
        on_ground = 1'b1;
        step();
        check_out("ceil_land", 0, 0, 0, 1);
        keycode1 = 8'h00;
        step();

        // Walk off a ledge with a simultaneous up press: no jump.
        keycode0 = 8'h4F;
        step();
        check_out("walk2", 2, 0, 1, 1);
        keycode1 = 8'h52;
        on_ground = 1'b0;
        step();
        check_out("ledge_fall", 2, 6, 3, 1);
        keycode3 = 8'h51;
        step();
        check_out("fast_fall", 2, 9, 3, 1);
        keycode3 = 8'h00;
        step();
        check_out("slow_fall", 2, 6, 3, 1);

        // Air control to the left.
        keycode0 = 8'h00; keycode1 = 8'h50;
        step();
        check_out("air_left", -2, 6, 3, 0);
        keycode1 = 8'h00;
        step();
        check_out("air_none", 0, 6, 3, 0);

        // Reset while rising with the counter at 7.
        on_ground = 1'b1;
        step();
        check_out("land2", 0, 0, 0, 0);
        keycode1 = 8'h52;
        step();
        check_out("rr_rise1", 0, -6, 2, 0);
        on_ground = 1'b0;
        repeat (6) step();
        check_out("rr_rise7", 0, -6, 2, 0);
        #2;
        Reset = 1'b1;
        #1;
        check_out("async_reset", 0, 0, 0, 1);
        on_ground = 1'b1;
        @(negedge frame_clk);
        Reset = 1'b0;
        step();
        check_out("post_reset_jump", 0, -6, 2, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
